count_wrap_tracker: RTL

COUNT_WRAP_TRACKER -- requirements
Module: count_wrap_tracker

---
 rtl/count_wrap_pkg.sv | 7 +
 rtl/count_step_classify.sv | 18 +
 rtl/count_wrap_tracker.sv | 128 ++++++++++++
 3 files changed

// File: rtl/count_wrap_pkg.sv
// count_wrap_pkg: shared FSM/step encodings and Turns limits for count_wrap_tracker
package count_wrap_pkg;
  typedef enum logic [1:0] {ST_INIT, ST_TRACK, ST_RESYNC} state_t;
  typedef enum logic [1:0] {STEP_HOLD, STEP_INC, STEP_DEC, STEP_JUMP} step_t;
  localparam logic signed [7:0] TURNS_MAX = 8'sh7f;
  localparam logic signed [7:0] TURNS_MIN = 8'sh80;
endpackage

// File: rtl/count_step_classify.sv
// count_step_classify: classifies the mod-16 step from the previous to the current counter sample
module count_step_classify
  import count_wrap_pkg::*;
(
  input  logic [3:0] i_count,
  input  logic [3:0] i_prev,
  output step_t      o_step,
  output logic       o_wrap_up,
  output logic       o_wrap_dn
);
  logic [3:0] w_delta;
  assign w_delta = i_count - i_prev;
  assign o_step = (w_delta == 4'd0) ? STEP_HOLD :
                  (w_delta == 4'd1) ? STEP_INC  :
                  (w_delta == 4'hf) ? STEP_DEC  : STEP_JUMP;
  assign o_wrap_up = (o_step == STEP_INC) && (i_prev == 4'hf);
  assign o_wrap_dn = (o_step == STEP_DEC) && (i_prev == 4'h0);
endmodule

// File: rtl/count_wrap_tracker.sv
// count_wrap_tracker: extends a 4-bit up/down counter into a signed wrap count with error flags.
// Optional stall detection is built when COUNT_WRAP_STALL_DETECT_EN is defined.
module count_wrap_tracker
  import count_wrap_pkg::*;
#(
  parameter bit UP_LEVEL     = 1'b1,
  parameter int STALL_CYCLES = 16
) (
  input  logic              Clk,
  input  logic              reset,
  input  logic [3:0]        Count,
  input  logic              UpOrDown,
  output logic              Valid,
  output logic              Ovf,
  output logic              Unf,
  output logic signed [7:0] Turns,
  output logic [11:0]       ExtCount,
  output logic              Jump,
  output logic              DirErr,
  output logic              Sat,
  output logic              Stall
);
  state_t            r_state, w_state_n;
  logic [3:0]        r_prev, w_prev_n;
  logic signed [7:0] r_turns, w_turns_n;
  logic              r_valid, r_ovf, r_unf, r_jump, r_dir_err, r_sat;
  logic              w_valid_n, w_ovf_n, w_unf_n, w_jump_n, w_dir_err_n, w_sat_n;
  step_t             w_step;
  logic              w_wrap_up, w_wrap_dn;
  count_step_classify u_classify (
    .i_count  (Count),
    .i_prev   (r_prev),
    .o_step   (w_step),
    .o_wrap_up(w_wrap_up),
    .o_wrap_dn(w_wrap_dn)
  );
  always_comb begin
    w_state_n   = r_state;
    w_prev_n    = Count;
    w_turns_n   = r_turns;
    w_valid_n   = 1'b1;
    w_ovf_n     = 1'b0;
    w_unf_n     = 1'b0;
    w_jump_n    = 1'b0;
    w_dir_err_n = 1'b0;
    w_sat_n     = r_sat;
    case (r_state)
      ST_INIT: begin
        w_turns_n = '0;
        w_state_n = ST_TRACK;
      end
      ST_TRACK: begin
        w_ovf_n     = w_wrap_up;
        w_unf_n     = w_wrap_dn;
        w_dir_err_n = (w_step == STEP_INC && UpOrDown != UP_LEVEL) ||
                      (w_step == STEP_DEC && UpOrDown == UP_LEVEL);
        if (w_wrap_up) begin
          if (r_turns == TURNS_MAX) w_sat_n = 1'b1;
          else w_turns_n = r_turns + 8'sd1;
        end
        if (w_wrap_dn) begin
          if (r_turns == TURNS_MIN) w_sat_n = 1'b1;
          else w_turns_n = r_turns - 8'sd1;
        end
        // a jump loses the turn history, so the baseline is rebuilt via RESYNC
        if (w_step == STEP_JUMP) begin
          w_jump_n  = 1'b1;
          w_turns_n = '0;
          w_sat_n   = 1'b0;
          w_valid_n = 1'b0;
          w_state_n = ST_RESYNC;
        end
      end
      default: w_state_n = ST_TRACK;
    endcase
  end
  always_ff @(posedge Clk) begin
    if (reset) begin
      r_state   <= ST_INIT;
      r_prev    <= '0;
      r_turns   <= '0;
      r_valid   <= 1'b0;
      r_ovf     <= 1'b0;
      r_unf     <= 1'b0;
      r_jump    <= 1'b0;
      r_dir_err <= 1'b0;
      r_sat     <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_prev    <= w_prev_n;
      r_turns   <= w_turns_n;
      r_valid   <= w_valid_n;
      r_ovf     <= w_ovf_n;
      r_unf     <= w_unf_n;
      r_jump    <= w_jump_n;
      r_dir_err <= w_dir_err_n;
      r_sat     <= w_sat_n;
    end
  end
`ifdef COUNT_WRAP_STALL_DETECT_EN
  localparam logic [7:0] STALL_LIM = 8'(STALL_CYCLES);
  logic [7:0] r_stall_cnt;
  logic       r_stall, w_hold;
  assign w_hold = (r_state == ST_TRACK) && (w_step == STEP_HOLD);
  always_ff @(posedge Clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_stall     <= 1'b0;
    end else begin
      r_stall_cnt <= !w_hold ? 8'd0 : (r_stall_cnt == STALL_LIM) ? r_stall_cnt : r_stall_cnt + 8'd1;
      r_stall     <= w_hold && (r_stall_cnt >= STALL_LIM - 8'd1);
    end
  end
  assign Stall = r_stall;
`else
  logic w_unused_cfg;
  assign w_unused_cfg = ^8'(STALL_CYCLES);
  assign Stall = 1'b0;
`endif
  assign Valid    = r_valid;
  assign Ovf      = r_ovf;
  assign Unf      = r_unf;
  assign Jump     = r_jump;
  assign DirErr   = r_dir_err;
  assign Sat      = r_sat;
  assign Turns    = r_turns;
  assign ExtCount = {r_turns, r_prev};
endmodule
